mem_mshr_queue: RTL and testbench
=================================

MEM_MSHR_QUEUE -- requirements
Module: mem_mshr_queue

Interface
REQ-001 The block SHALL have parameter NUM_ENTRIES, default 4, number of MSHR entries (2..16).
REQ-002 The block SHALL have parameter ADDR_W, default 27, miss block-address width.
REQ-003 The block SHALL have parameter LAT_W, default 5, miss-latency counter width.
REQ-004 The block SHALL have parameter WARP_W, default 3, warp ID width; SCB_W, default 2, scoreboard ID width; MASK_W, default 8, thread-mask width.
REQ-005 clk  input  1  clock, all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 req_valid  input  1  miss request from stage 2, one per cycle.
REQ-008 req_addr  input  ADDR_W  block address; req_latency  input  LAT_W  miss latency in cycles.
REQ-009 req_warp  input  WARP_W; req_scb  input  SCB_W; req_mask  input  MASK_W; req_reg  input  5  destination register.
REQ-010 neg_fb_valid  output  1  reject pulse to scoreboard; neg_fb_warp, neg_fb_scb, neg_fb_addr  outputs  request fields of rejected miss.
REQ-011 fill_valid  output  1  completion pulse; fill_addr, fill_warp, fill_scb, fill_mask, fill_reg  outputs  fields of completed entry.
REQ-012 full  output  1  all entries valid; occupancy  output  $clog2(NUM_ENTRIES+1)  count of valid entries.

Function
REQ-013 Each entry SHALL hold valid, addr, warp, scb, mask, reg and a LAT_W-bit countdown.
REQ-014 A request SHALL be accepted when req_valid=1, full=0 and req_addr matches no valid entry; it SHALL be written at that edge into the lowest-index invalid entry, countdown = req_latency.
REQ-015 req_latency=0 SHALL be treated as 1.
REQ-016 A request with full=1 or an address match SHALL be rejected: no allocation; neg_fb_valid=1 for exactly the next cycle, neg_fb_* = request fields.
REQ-017 Full and address match SHALL be evaluated on pre-edge state; an entry released at the same edge SHALL still count as valid (still full, still matching).
REQ-018 Each valid entry with countdown>0 SHALL decrement by 1 per edge; countdown saturates at 0.
REQ-019 An entry with countdown=0 is ready; at each edge the lowest-index ready entry SHALL be released (valid cleared) and its fields registered onto fill_*, with fill_valid=1 for the next cycle only.
REQ-020 At most one release per edge; other ready entries SHALL wait, keeping countdown 0 and valid=1.
REQ-021 Without contention, fill_valid SHALL be high in the cycle after the edge L+1 edges after the accepting edge (L = effective latency); with L=3, accept at edge E0 -> release at E4 -> fill_valid high after E4.
REQ-022 Allocation, release and reject SHALL occur in the same edge when conditions coincide; occupancy SHALL reflect both (+1 -1 = unchanged).
REQ-023 neg_fb_* and fill_* field outputs SHALL hold last value when their valid is 0.
REQ-024 full and occupancy SHALL be registered state, updated at the same edge as entry valid bits.

Reset
REQ-025 rst=0 SHALL asynchronously clear all entry valid bits, countdowns, neg_fb_valid, fill_valid, full, occupancy and all field outputs to 0.
REQ-026 Entries in flight at reset SHALL be discarded with no fill or reject pulse after rst deasserts.
REQ-027 The first edge after rst rises SHALL accept requests normally.

Verification
REQ-028 Single miss addr=0x10, latency=3 at E0 -> fill_valid pulse after E4, fill_addr=0x10, occupancy 1 then 0.
REQ-029 Five distinct misses back-to-back, latency=20, NUM_ENTRIES=4 -> fifth gets neg_fb_valid pulse with its warp/scb/addr; full=1, occupancy=4.
REQ-030 Second miss to pending addr 0x22 -> neg_fb_valid, neg_fb_addr=0x22; no allocation; single fill later.
REQ-031 Two misses latency 1 and 2, accepted on consecutive edges, both ready same edge -> lower-index entry fills first, other one cycle later; no pulse lost.
REQ-032 Full queue, entry completing while new request arrives same edge -> request rejected, occupancy 4->3; next-cycle request accepted.
REQ-033 rst asserted with 3 pending entries -> all outputs 0 immediately; no fill pulses after release; new miss latency=0 fills after 2 edges.

Source files
------------

// File: rtl/mem_mshr_queue.sv
`default_nettype none
// ============================================================================
// mem_mshr_queue : MSHR table with per-entry latency countdown, duplicate and
//                  overflow rejection, and at most one fill per cycle.
// Revision       : 1.0
// ============================================================================
module mem_mshr_queue #(
   parameter int NUM_ENTRIES = 4,
   parameter int ADDR_W      = 27,
   parameter int LAT_W       = 5,
   parameter int WARP_W      = 3,
   parameter int SCB_W       = 2,
   parameter int MASK_W      = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 req_valid,
   input  logic [ADDR_W-1:0]                    req_addr,
   input  logic [LAT_W-1:0]                     req_latency,
   input  logic [WARP_W-1:0]                    req_warp,
   input  logic [SCB_W-1:0]                     req_scb,
   input  logic [MASK_W-1:0]                    req_mask,
   input  logic [4:0]                           req_reg,
   output logic                                 neg_fb_valid,
   output logic [WARP_W-1:0]                    neg_fb_warp,
   output logic [SCB_W-1:0]                     neg_fb_scb,
   output logic [ADDR_W-1:0]                    neg_fb_addr,
   output logic                                 fill_valid,
   output logic [ADDR_W-1:0]                    fill_addr,
   output logic [WARP_W-1:0]                    fill_warp,
   output logic [SCB_W-1:0]                     fill_scb,
   output logic [MASK_W-1:0]                    fill_mask,
   output logic [4:0]                           fill_reg,
   output logic                                 full,
   output logic [$clog2(NUM_ENTRIES+1)-1:0]     occupancy
);

   localparam int IDX_W = $clog2(NUM_ENTRIES);
   localparam int OCC_W = $clog2(NUM_ENTRIES+1);

   logic [NUM_ENTRIES-1:0] r_valid;
   logic [ADDR_W-1:0]      r_addr [NUM_ENTRIES];
   logic [WARP_W-1:0]      r_warp [NUM_ENTRIES];
   logic [SCB_W-1:0]       r_scb  [NUM_ENTRIES];
   logic [MASK_W-1:0]      r_mask [NUM_ENTRIES];
   logic [4:0]             r_reg  [NUM_ENTRIES];
   logic [LAT_W-1:0]       r_cnt  [NUM_ENTRIES];
   logic [OCC_W-1:0]       r_occ;
   logic                   r_full;

   logic                   r_neg_valid;
   logic [WARP_W-1:0]      r_neg_warp;
   logic [SCB_W-1:0]       r_neg_scb;
   logic [ADDR_W-1:0]      r_neg_addr;
   logic                   r_fill_valid;
   logic [ADDR_W-1:0]      r_fill_addr;
   logic [WARP_W-1:0]      r_fill_warp;
   logic [SCB_W-1:0]       r_fill_scb;
   logic [MASK_W-1:0]      r_fill_mask;
   logic [4:0]             r_fill_reg;

   logic                   w_match;
   logic                   w_free_found;
   logic [IDX_W-1:0]       w_free_idx;
   logic                   w_rel_found;
   logic [IDX_W-1:0]       w_rel_idx;
   logic                   w_accept;
   logic                   w_reject;
   logic [LAT_W-1:0]       w_lat_eff;
   logic [OCC_W-1:0]       w_occ_next;

   // All decisions look only at pre-edge state, so an entry released this
   // edge still blocks a matching or overflowing request.
   always_comb begin
      w_match      = 1'b0;
      w_free_found = 1'b0;
      w_free_idx   = '0;
      w_rel_found  = 1'b0;
      w_rel_idx    = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (r_valid[i] && (r_addr[i] == req_addr)) begin
            w_match = 1'b1;
         end
         if (!r_valid[i] && !w_free_found) begin
            w_free_found = 1'b1;
            w_free_idx   = IDX_W'(i);
         end
         if (r_valid[i] && (r_cnt[i] == '0) && !w_rel_found) begin
            w_rel_found = 1'b1;
            w_rel_idx   = IDX_W'(i);
         end
      end
   end

   assign w_accept   = req_valid & ~r_full & ~w_match & w_free_found;
   assign w_reject   = req_valid & (r_full | w_match);
   assign w_lat_eff  = (req_latency == '0) ? LAT_W'(1) : req_latency;
   assign w_occ_next = r_occ + OCC_W'(w_accept) - OCC_W'(w_rel_found);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            r_addr[i] <= '0;
            r_warp[i] <= '0;
            r_scb[i]  <= '0;
            r_mask[i] <= '0;
            r_reg[i]  <= '0;
            r_cnt[i]  <= '0;
         end
         r_occ        <= '0;
         r_full       <= 1'b0;
         r_neg_valid  <= 1'b0;
         r_neg_warp   <= '0;
         r_neg_scb    <= '0;
         r_neg_addr   <= '0;
         r_fill_valid <= 1'b0;
         r_fill_addr  <= '0;
         r_fill_warp  <= '0;
         r_fill_scb   <= '0;
         r_fill_mask  <= '0;
         r_fill_reg   <= '0;
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_rel_found && (w_rel_idx == IDX_W'(i))) begin
               r_valid[i] <= 1'b0;
            end else if (r_valid[i] && (r_cnt[i] != '0)) begin
               r_cnt[i] <= r_cnt[i] - LAT_W'(1);
            end
            // The allocated slot was invalid pre-edge, so it never collides with the release.
            if (w_accept && (w_free_idx == IDX_W'(i))) begin
               r_valid[i] <= 1'b1;
               r_addr[i]  <= req_addr;
               r_warp[i]  <= req_warp;
               r_scb[i]   <= req_scb;
               r_mask[i]  <= req_mask;
               r_reg[i]   <= req_reg;
               r_cnt[i]   <= w_lat_eff;
            end
         end
         r_fill_valid <= w_rel_found;
         if (w_rel_found) begin
            r_fill_addr <= r_addr[w_rel_idx];
            r_fill_warp <= r_warp[w_rel_idx];
            r_fill_scb  <= r_scb[w_rel_idx];
            r_fill_mask <= r_mask[w_rel_idx];
            r_fill_reg  <= r_reg[w_rel_idx];
         end
         r_neg_valid <= w_reject;
         if (w_reject) begin
            r_neg_warp <= req_warp;
            r_neg_scb  <= req_scb;
            r_neg_addr <= req_addr;
         end
         r_occ  <= w_occ_next;
         r_full <= (w_occ_next == OCC_W'(NUM_ENTRIES));
      end
   end

   assign neg_fb_valid = r_neg_valid;
   assign neg_fb_warp  = r_neg_warp;
   assign neg_fb_scb   = r_neg_scb;
   assign neg_fb_addr  = r_neg_addr;
   assign fill_valid   = r_fill_valid;
   assign fill_addr    = r_fill_addr;
   assign fill_warp    = r_fill_warp;
   assign fill_scb     = r_fill_scb;
   assign fill_mask    = r_fill_mask;
   assign fill_reg     = r_fill_reg;
   assign full         = r_full;
   assign occupancy    = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_mem_mshr_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_mem_mshr_queue : directed scenarios plus randomized traffic against a
//                     ready-time based reference model.
// Revision          : 1.0
// ============================================================================
module tb_mem_mshr_queue;

   localparam int N  = 4;
   localparam int AW = 27;
   localparam int LW = 5;
   localparam int WW = 3;
   localparam int SW = 2;
   localparam int MW = 8;
   localparam int OW = $clog2(N+1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req_valid = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [LW-1:0] req_latency = '0;
   logic [WW-1:0] req_warp = '0;
   logic [SW-1:0] req_scb = '0;
   logic [MW-1:0] req_mask = '0;
   logic [4:0]    req_reg = '0;
   logic          neg_fb_valid;
   logic [WW-1:0] neg_fb_warp;
   logic [SW-1:0] neg_fb_scb;
   logic [AW-1:0] neg_fb_addr;
   logic          fill_valid;
   logic [AW-1:0] fill_addr;
   logic [WW-1:0] fill_warp;
   logic [SW-1:0] fill_scb;
   logic [MW-1:0] fill_mask;
   logic [4:0]    fill_reg;
   logic          full;
   logic [OW-1:0] occupancy;

   mem_mshr_queue #(
      .NUM_ENTRIES(N), .ADDR_W(AW), .LAT_W(LW), .WARP_W(WW), .SCB_W(SW), .MASK_W(MW)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr), .req_latency(req_latency),
      .req_warp(req_warp), .req_scb(req_scb), .req_mask(req_mask), .req_reg(req_reg),
      .neg_fb_valid(neg_fb_valid), .neg_fb_warp(neg_fb_warp), .neg_fb_scb(neg_fb_scb),
      .neg_fb_addr(neg_fb_addr),
      .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_warp(fill_warp),
      .fill_scb(fill_scb), .fill_mask(fill_mask), .fill_reg(fill_reg),
      .full(full), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: each entry remembers the absolute edge at which it may be released.
   bit            m_valid [N];
   logic [AW-1:0] m_addr  [N];
   logic [WW-1:0] m_warp  [N];
   logic [SW-1:0] m_scb   [N];
   logic [MW-1:0] m_mask  [N];
   logic [4:0]    m_reg   [N];
   int            m_ready [N];
   int            m_edge;
   logic          e_fill_valid, e_neg_valid;
   logic [AW-1:0] e_fill_addr, e_neg_addr;
   logic [WW-1:0] e_fill_warp, e_neg_warp;
   logic [SW-1:0] e_fill_scb, e_neg_scb;
   logic [MW-1:0] e_fill_mask;
   logic [4:0]    e_fill_reg;
   int            e_occ;

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 0;
         m_ready[i] = 0;
      end
      m_edge = 0;
      e_fill_valid = 0; e_neg_valid = 0;
      e_fill_addr = '0; e_fill_warp = '0; e_fill_scb = '0; e_fill_mask = '0; e_fill_reg = '0;
      e_neg_addr = '0; e_neg_warp = '0; e_neg_scb = '0;
      e_occ = 0;
   endtask

   task automatic model_step();
      int rel, free, occ;
      bit hit, rej;
      rel = -1; free = -1; occ = 0; hit = 0;
      for (int i = 0; i < N; i++) begin
         if (m_valid[i]) begin
            occ++;
            if (m_addr[i] == req_addr) hit = 1;
            if (rel < 0 && m_edge >= m_ready[i]) rel = i;
         end else if (free < 0) begin
            free = i;
         end
      end
      rej = req_valid && (occ == N || hit);
      e_neg_valid  = rej;
      e_fill_valid = (rel >= 0);
      if (rej) begin
         e_neg_addr = req_addr; e_neg_warp = req_warp; e_neg_scb = req_scb;
      end
      if (rel >= 0) begin
         e_fill_addr = m_addr[rel]; e_fill_warp = m_warp[rel]; e_fill_scb = m_scb[rel];
         e_fill_mask = m_mask[rel]; e_fill_reg = m_reg[rel];
         m_valid[rel] = 0;
      end
      if (req_valid && !rej) begin
         m_valid[free] = 1;
         m_addr[free] = req_addr; m_warp[free] = req_warp; m_scb[free] = req_scb;
         m_mask[free] = req_mask; m_reg[free] = req_reg;
         m_ready[free] = m_edge + ((req_latency == 0) ? 1 : int'(req_latency)) + 1;
      end
      m_edge++;
      e_occ = 0;
      for (int i = 0; i < N; i++) if (m_valid[i]) e_occ++;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic cycle(input bit v, input int a, input int lat, input int w, input int s);
      req_valid   = v;
      req_addr    = AW'(a);
      req_latency = LW'(lat);
      req_warp    = WW'(w);
      req_scb     = SW'(s);
      req_mask    = MW'(a) ^ 8'hA5;
      req_reg     = 5'(a + 1);
      tick();
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      total++;
      if ({fill_valid, neg_fb_valid, full, occupancy, fill_addr, neg_fb_addr} !== '0) begin
         bad++;
         $display("FAIL reset_state: fv=%0b nv=%0b full=%0b occ=%0d fa=%0h na=%0h, want all 0",
                  fill_valid, neg_fb_valid, full, occupancy, fill_addr, neg_fb_addr);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      cycle(1, 'h10, 3, 2, 1);
      for (int e = 0; e < 6; e++) begin
         total++;
         if (fill_valid !== (e == 4)) begin
            bad++;
            $display("FAIL single_fill_valid edge%0d: got %0b want %0b", e, fill_valid, (e == 4));
         end
         total++;
         if (occupancy !== OW'((e < 4) ? 1 : 0)) begin
            bad++;
            $display("FAIL single_occ edge%0d: got %0d want %0d", e, occupancy, (e < 4) ? 1 : 0);
         end
         if (e == 4) begin
            total++;
            if (fill_addr !== AW'('h10) || fill_warp !== 3'd2 || fill_scb !== 2'd1) begin
               bad++;
               $display("FAIL single_fields: addr=%0h warp=%0d scb=%0d want 10/2/1",
                        fill_addr, fill_warp, fill_scb);
            end
         end
         if (e < 5) idle();
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1, 'h100 + i, 20, i + 2, i + 3);
      total++;
      if (neg_fb_valid !== 1'b1 || neg_fb_addr !== AW'('h104) || neg_fb_warp !== 3'd6 || neg_fb_scb !== 2'd3) begin
         bad++;
         $display("FAIL overflow_reject: v=%0b addr=%0h warp=%0d scb=%0d want 1/104/6/3",
                  neg_fb_valid, neg_fb_addr, neg_fb_warp, neg_fb_scb);
      end
      total++;
      if (full !== 1'b1 || occupancy !== OW'(4)) begin
         bad++;
         $display("FAIL overflow_full: full=%0b occ=%0d want 1/4", full, occupancy);
      end
      idle();
      total++;
      if (neg_fb_valid !== 1'b0 || neg_fb_addr !== AW'('h104)) begin
         bad++;
         $display("FAIL overflow_pulse_hold: v=%0b addr=%0h want 0/104", neg_fb_valid, neg_fb_addr);
      end
   endtask

   task automatic test_addr_match();
      int fills;
      do_reset();
      cycle(1, 'h22, 5, 1, 0);
      cycle(1, 'h22, 2, 5, 2);
      total++;
      if (neg_fb_valid !== 1'b1 || neg_fb_addr !== AW'('h22) || occupancy !== OW'(1)) begin
         bad++;
         $display("FAIL match_reject: v=%0b addr=%0h occ=%0d want 1/22/1",
                  neg_fb_valid, neg_fb_addr, occupancy);
      end
      fills = 0;
      for (int k = 0; k < 12; k++) begin
         idle();
         if (fill_valid === 1'b1) fills++;
      end
      total++;
      if (fills != 1) begin
         bad++;
         $display("FAIL match_single_fill: got %0d fills want 1", fills);
      end
   endtask

   task automatic test_same_ready();
      do_reset();
      cycle(1, 'h30, 2, 1, 1);
      cycle(1, 'h31, 1, 2, 2);
      idle();
      total++;
      if (fill_valid !== 1'b0) begin
         bad++;
         $display("FAIL same_ready_early: got %0b want 0", fill_valid);
      end
      idle();
      total++;
      if (fill_valid !== 1'b1 || fill_addr !== AW'('h30)) begin
         bad++;
         $display("FAIL same_ready_first: v=%0b addr=%0h want 1/30", fill_valid, fill_addr);
      end
      idle();
      total++;
      if (fill_valid !== 1'b1 || fill_addr !== AW'('h31) || occupancy !== OW'(0)) begin
         bad++;
         $display("FAIL same_ready_second: v=%0b addr=%0h occ=%0d want 1/31/0",
                  fill_valid, fill_addr, occupancy);
      end
      idle();
      total++;
      if (fill_valid !== 1'b0) begin
         bad++;
         $display("FAIL same_ready_after: got %0b want 0", fill_valid);
      end
   endtask

   task automatic test_full_release();
      do_reset();
      cycle(1, 'h40, 3, 1, 1);
      for (int i = 1; i < 4; i++) cycle(1, 'h40 + i, 20, 1, 1);
      total++;
      if (full !== 1'b1 || occupancy !== OW'(4)) begin
         bad++;
         $display("FAIL fullrel_prefill: full=%0b occ=%0d want 1/4", full, occupancy);
      end
      cycle(1, 'h44, 2, 3, 2);
      total++;
      if (neg_fb_valid !== 1'b1 || neg_fb_addr !== AW'('h44) || fill_valid !== 1'b1 ||
          fill_addr !== AW'('h40) || occupancy !== OW'(3) || full !== 1'b0) begin
         bad++;
         $display("FAIL fullrel_same_edge: nv=%0b na=%0h fv=%0b fa=%0h occ=%0d full=%0b want 1/44/1/40/3/0",
                  neg_fb_valid, neg_fb_addr, fill_valid, fill_addr, occupancy, full);
      end
      cycle(1, 'h45, 2, 3, 2);
      total++;
      if (neg_fb_valid !== 1'b0 || occupancy !== OW'(4) || full !== 1'b1) begin
         bad++;
         $display("FAIL fullrel_next_accept: nv=%0b occ=%0d full=%0b want 0/4/1",
                  neg_fb_valid, occupancy, full);
      end
   endtask

   task automatic test_reset_inflight();
      int pulses;
      do_reset();
      cycle(1, 'h5, 0, 1, 1);
      idle();
      idle();
      for (int i = 0; i < 3; i++) cycle(1, 'h50 + i, 10, 2, 2);
      cycle(1, 'h50, 10, 4, 3);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      total++;
      if ({fill_valid, neg_fb_valid, full, occupancy, fill_addr, neg_fb_addr, neg_fb_warp, fill_mask} !== '0) begin
         bad++;
         $display("FAIL inflight_async_clear: fv=%0b nv=%0b occ=%0d fa=%0h na=%0h nw=%0d fm=%0h want all 0",
                  fill_valid, neg_fb_valid, occupancy, fill_addr, neg_fb_addr, neg_fb_warp, fill_mask);
      end
      @(negedge clk);
      rst = 1'b1;
      pulses = 0;
      for (int k = 0; k < 15; k++) begin
         idle();
         if (fill_valid === 1'b1 || neg_fb_valid === 1'b1) pulses++;
      end
      total++;
      if (pulses != 0) begin
         bad++;
         $display("FAIL inflight_no_pulse: got %0d pulses want 0", pulses);
      end
      cycle(1, 'h60, 0, 1, 1);
      idle();
      total++;
      if (fill_valid !== 1'b0) begin
         bad++;
         $display("FAIL inflight_lat0_early: got %0b want 0", fill_valid);
      end
      idle();
      total++;
      if (fill_valid !== 1'b1 || fill_addr !== AW'('h60)) begin
         bad++;
         $display("FAIL inflight_lat0_fill: v=%0b addr=%0h want 1/60", fill_valid, fill_addr);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 400; n++) begin
         req_valid   = ($urandom_range(0, 9) < 6);
         req_addr    = AW'('h200 + $urandom_range(0, 7));
         req_latency = LW'($urandom_range(0, 6));
         req_warp    = WW'($urandom);
         req_scb     = SW'($urandom);
         req_mask    = MW'($urandom);
         req_reg     = 5'($urandom);
         tick();
         total++;
         if (fill_valid !== e_fill_valid || neg_fb_valid !== e_neg_valid) begin
            bad++;
            $display("FAIL rand_valids cyc%0d: fv=%0b nv=%0b want %0b/%0b",
                     n, fill_valid, neg_fb_valid, e_fill_valid, e_neg_valid);
         end
         total++;
         if (occupancy !== OW'(e_occ) || full !== (e_occ == N)) begin
            bad++;
            $display("FAIL rand_occ cyc%0d: occ=%0d full=%0b want %0d/%0b",
                     n, occupancy, full, e_occ, (e_occ == N));
         end
         total++;
         if (fill_addr !== e_fill_addr || fill_warp !== e_fill_warp || fill_scb !== e_fill_scb ||
             fill_mask !== e_fill_mask || fill_reg !== e_fill_reg) begin
            bad++;
            $display("FAIL rand_fill_fields cyc%0d: %0h/%0d/%0d/%0h/%0d want %0h/%0d/%0d/%0h/%0d", n,
                     fill_addr, fill_warp, fill_scb, fill_mask, fill_reg,
                     e_fill_addr, e_fill_warp, e_fill_scb, e_fill_mask, e_fill_reg);
         end
         total++;
         if (neg_fb_addr !== e_neg_addr || neg_fb_warp !== e_neg_warp || neg_fb_scb !== e_neg_scb) begin
            bad++;
            $display("FAIL rand_neg_fields cyc%0d: %0h/%0d/%0d want %0h/%0d/%0d", n,
                     neg_fb_addr, neg_fb_warp, neg_fb_scb, e_neg_addr, e_neg_warp, e_neg_scb);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_addr_match();
      test_same_ready();
      test_full_release();
      test_reset_inflight();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
